vdp_cpu_port: RTL and testbench

//  CPU-side port controller for the VDP. Decodes data/control port accesses into

---
 rtl/vdp_cpu_port.sv | 160 ++++++++++++++++
 tb/tb_vdp_cpu_port.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vdp_cpu_port.sv
// CPU-side VDP port: control latch, register writes, auto-incrementing VRAM
// address with read-ahead buffer, VRAM req/ack handshake and status flags.
module vdp_cpu_port #(
  parameter int ADDR_W   = 14,
  parameter int NUM_REGS = 8,
  parameter int HI_REG   = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  port_sel,
  input  logic                  wr_stb,
  input  logic                  rd_stb,
  input  logic [7:0]            cpu_din,
  output logic [7:0]            cpu_dout,
  output logic                  vram_req,
  output logic                  vram_we,
  output logic [ADDR_W-1:0]     vram_addr,
  output logic [7:0]            vram_wdata,
  input  logic                  vram_ack,
  input  logic [7:0]            vram_rdata,
  input  logic                  int_set,
  input  logic                  coll_set,
  input  logic                  fifth_set,
  input  logic [4:0]            fifth_num,
  output logic [NUM_REGS*8-1:0] regs,
  output logic                  int_n,
  output logic                  busy,
  output logic                  overrun
);

  typedef enum logic {LATCH_IDLE, LATCH_FIRST} latch_t;
  typedef enum logic {ST_IDLE, ST_WAIT_ACK} vram_st_t;

  latch_t            latch_q;
  vram_st_t          state_q, state_d;
  logic [7:0]        first_byte;
  logic [7:0]        reg_file [NUM_REGS];
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  logic [7:0]        rd_buf;
  logic              int_flag, coll_flag, fifth_flag;
  logic [4:0]        fifth_num_q;
  logic              overrun_q;
  logic [7:0]        hi_reg_val;

  logic              data_acc, ctrl_wr, stat_rd, second_wr, reg_wr, addr_ld, prefetch;
  logic              start_req, start, start_we;
  logic [21:0]       full_addr;
  logic [ADDR_W-1:0] new_addr, acc_addr_next;

  generate
    if (HI_REG < NUM_REGS) begin : g_hi
      assign hi_reg_val = reg_file[HI_REG];
    end else begin : g_no_hi
      assign hi_reg_val = 8'h00;
    end
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
      assign regs[8*g +: 8] = reg_file[g];
    end
  endgenerate

  // Access decode
  always_comb begin
    data_acc      = ~port_sel & (wr_stb | rd_stb);
    ctrl_wr       = port_sel & wr_stb;
    stat_rd       = port_sel & rd_stb;
    second_wr     = ctrl_wr & (latch_q == LATCH_FIRST);
    reg_wr        = second_wr & cpu_din[7];
    addr_ld       = second_wr & ~cpu_din[7];
    prefetch      = addr_ld & ~cpu_din[6];
    start_req     = data_acc | prefetch;
    start         = start_req & (state_q == ST_IDLE);
    start_we      = data_acc & wr_stb;
    full_addr     = {hi_reg_val, cpu_din[5:0], first_byte};
    new_addr      = full_addr[ADDR_W-1:0];
    acc_addr_next = prefetch ? new_addr : addr_q;
  end

  // VRAM handshake next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (start) state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: if (vram_ack) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      latch_q     <= LATCH_IDLE;
      first_byte  <= 8'h00;
      addr_q      <= '0;
      acc_addr    <= '0;
      acc_we      <= 1'b0;
      rd_buf      <= 8'h00;
      overrun_q   <= 1'b0;
      int_flag    <= 1'b0;
      coll_flag   <= 1'b0;
      fifth_flag  <= 1'b0;
      fifth_num_q <= 5'h00;
      for (int i = 0; i < NUM_REGS; i++) reg_file[i] <= 8'h00;
    end else begin
      if (data_acc || stat_rd) begin
        latch_q <= LATCH_IDLE;
      end else if (ctrl_wr) begin
        if (latch_q == LATCH_IDLE) begin
          first_byte <= cpu_din;
          latch_q    <= LATCH_FIRST;
        end else begin
          latch_q <= LATCH_IDLE;
        end
      end

      for (int i = 0; i < NUM_REGS; i++)
        if (reg_wr && cpu_din[5:0] == 6'(i)) reg_file[i] <= first_byte;

      // A new access captures its address; the pointer moves past it
      if (start) begin
        acc_addr <= acc_addr_next;
        acc_we   <= start_we;
        addr_q   <= acc_addr_next + ADDR_W'(1);
      end else if (addr_ld && !prefetch) begin
        addr_q <= new_addr;
      end

      if (start && start_we)
        rd_buf <= cpu_din;
      else if (state_q == ST_WAIT_ACK && vram_ack && !acc_we)
        rd_buf <= vram_rdata;

      if (start_req && state_q == ST_WAIT_ACK) overrun_q <= 1'b1;

      // Set events take priority over the read-triggered clear
      int_flag   <= int_set   | (int_flag   & ~stat_rd);
      coll_flag  <= coll_set  | (coll_flag  & ~stat_rd);
      fifth_flag <= fifth_set | (fifth_flag & ~stat_rd);
      if (fifth_set && !fifth_flag) fifth_num_q <= fifth_num;
    end
  end

  always_comb begin
    vram_req   = (state_q == ST_WAIT_ACK);
    busy       = vram_req;
    vram_we    = acc_we;
    vram_addr  = busy ? acc_addr : addr_q;
    vram_wdata = rd_buf;
    overrun    = overrun_q;
    int_n      = ~(int_flag & reg_file[1][5]);
    cpu_dout   = port_sel ? {int_flag, fifth_flag, coll_flag, fifth_flag ? fifth_num_q : 5'h1f}
                          : rd_buf;
  end

endmodule

// File: tb/tb_vdp_cpu_port.sv
// Bench for vdp_cpu_port: directed steps then random traffic against a
// behavioural model of the port (integer address, flag bits, pending access).
module tb_vdp_cpu_port;
  localparam int ADDR_W   = 17;
  localparam int NUM_REGS = 16;
  localparam int HI_REG   = 14;
  localparam int AMOD     = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset, port_sel, wr_stb, rd_stb;
  logic [7:0] cpu_din, cpu_dout;
  logic vram_req, vram_we, vram_ack;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0] vram_wdata, vram_rdata;
  logic int_set, coll_set, fifth_set;
  logic [4:0] fifth_num;
  logic [NUM_REGS*8-1:0] regs;
  logic int_n, busy, overrun;

  vdp_cpu_port #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .HI_REG(HI_REG)) dut (
    .clk(clk), .reset(reset), .port_sel(port_sel), .wr_stb(wr_stb), .rd_stb(rd_stb),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .vram_req(vram_req), .vram_we(vram_we),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_ack(vram_ack),
    .vram_rdata(vram_rdata), .int_set(int_set), .coll_set(coll_set),
    .fifth_set(fifth_set), .fifth_num(fifth_num), .regs(regs), .int_n(int_n),
    .busy(busy), .overrun(overrun));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_regs [NUM_REGS];
  int         m_addr;
  logic [7:0] m_buf, m_first;
  bit         m_latch;
  bit         m_int, m_coll, m_fifth, m_over;
  logic [4:0] m_fnum;
  bit         m_pend, m_pwe;
  int         m_paddr;
  logic [7:0] m_pwdata;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {m_int, m_fifth, m_coll, m_fifth ? m_fnum : 5'h1f};
  endfunction

  function automatic logic [127:0] m_regvec();
    logic [127:0] v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[8*i +: 8] = m_regs[i];
    return v;
  endfunction

  function automatic void m_access(input bit we, input int a, input logic [7:0] wd);
    if (m_pend) begin
      m_over = 1;
    end else begin
      m_pend = 1; m_pwe = we; m_paddr = a; m_pwdata = wd;
      m_addr = (a + 1) % AMOD;
    end
  endfunction

  task automatic do_reset();
    reset = 1; port_sel = 0; wr_stb = 0; rd_stb = 0; cpu_din = 0; vram_ack = 0;
    vram_rdata = 0; int_set = 0; coll_set = 0; fifth_set = 0; fifth_num = 0;
    @(negedge clk); @(negedge clk);
    reset = 0;
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 0;
    m_addr = 0; m_buf = 0; m_first = 0; m_latch = 0; m_int = 0; m_coll = 0;
    m_fifth = 0; m_fnum = 0; m_over = 0; m_pend = 0; m_pwe = 0; m_paddr = 0; m_pwdata = 0;
  endtask

  task automatic ctrl_wr(input logic [7:0] b);
    int na;
    port_sel = 1; cpu_din = b; wr_stb = 1;
    @(negedge clk);
    wr_stb = 0;
    if (!m_latch) begin
      m_first = b; m_latch = 1;
    end else begin
      m_latch = 0;
      if (b[7]) begin
        if (int'(b[5:0]) < NUM_REGS) m_regs[b[5:0]] = m_first;
      end else begin
        na = (int'(m_regs[HI_REG]) % (1 << (ADDR_W - 14))) * 16384 + int'(b[5:0]) * 256 + int'(m_first);
        if (!b[6]) begin
          if (m_pend) m_over = 1;
          else m_access(0, na, 8'h00);
        end else begin
          m_addr = na;
        end
      end
    end
  endtask

  task automatic data_wr(input logic [7:0] b);
    port_sel = 0; cpu_din = b; wr_stb = 1;
    @(negedge clk);
    wr_stb = 0;
    m_latch = 0;
    if (m_pend) m_over = 1;
    else begin m_buf = b; m_access(1, m_addr, b); end
  endtask

  task automatic data_rd();
    port_sel = 0; rd_stb = 1;
    #1 chk("data_rd_dout", 128'(cpu_dout), 128'(m_buf));
    @(negedge clk);
    rd_stb = 0;
    m_latch = 0;
    m_access(0, m_addr, 8'h00);
  endtask

  task automatic status_rd(input bit with_int);
    port_sel = 1; rd_stb = 1; int_set = with_int;
    #1 chk("status_dout", 128'(cpu_dout), 128'(m_status()));
    @(negedge clk);
    rd_stb = 0; int_set = 0;
    m_latch = 0; m_int = with_int; m_coll = 0; m_fifth = 0;
  endtask

  task automatic pulse_evt(input bit i, input bit c, input bit f, input logic [4:0] n);
    int_set = i; coll_set = c; fifth_set = f; fifth_num = n;
    @(negedge clk);
    int_set = 0; coll_set = 0; fifth_set = 0;
    if (f && !m_fifth) m_fnum = n;
    if (i) m_int = 1;
    if (c) m_coll = 1;
    if (f) m_fifth = 1;
  endtask

  task automatic serve(input int delay, input logic [7:0] rdata);
    for (int n = 0; n < 8 && !vram_req; n++) @(negedge clk);
    chk("req_seen", 128'(vram_req), 128'(1));
    for (int d = 0; d < delay; d++) @(negedge clk);
    chk("vram_addr", 128'(vram_addr), 128'(m_paddr));
    chk("vram_we", 128'(vram_we), 128'(m_pwe));
    if (m_pwe) chk("vram_wdata", 128'(vram_wdata), 128'(m_pwdata));
    vram_ack = 1; vram_rdata = rdata;
    @(negedge clk);
    vram_ack = 0;
    if (!m_pwe) m_buf = rdata;
    m_pend = 0;
    chk("req_drop", 128'(vram_req), 128'(0));
  endtask

  task automatic check_all();
    chk("regs", 128'(regs), m_regvec());
    chk("int_n", 128'(int_n), 128'(!(m_int && m_regs[1][5])));
    chk("overrun", 128'(overrun), 128'(m_over));
    chk("busy", 128'(busy), 128'(m_pend));
    port_sel = 1;
    #1 chk("status", 128'(cpu_dout), 128'(m_status()));
    port_sel = 0;
    #1 chk("buffer", 128'(cpu_dout), 128'(m_buf));
  endtask

  initial begin
    int unsigned op;
    do_reset();
    check_all();
    chk("reset_req", 128'(vram_req), 128'(0));

    // Write setup and data write with auto-increment
    ctrl_wr(8'h34); ctrl_wr(8'h52);
    data_wr(8'hAA); serve(0, 8'h00);
    data_wr(8'h55); serve(1, 8'h00);
    check_all();

    // Read setup prefetch then data read
    ctrl_wr(8'h00); ctrl_wr(8'h10);
    serve(2, 8'h5A);
    data_rd(); serve(0, 8'hC3);
    check_all();

    // Interrupt enable and status clear
    ctrl_wr(8'hE0); ctrl_wr(8'h81);
    pulse_evt(1, 0, 0, 5'd0);
    check_all();
    status_rd(0);
    check_all();
    status_rd(0);

    // Latch reset by a data access
    ctrl_wr(8'h12);
    data_rd(); serve(0, 8'h11);
    ctrl_wr(8'h34); ctrl_wr(8'h40);
    data_wr(8'h01); serve(0, 8'h00);
    check_all();

    // Sprite flags, fifth number latching, set beating clear
    pulse_evt(0, 1, 1, 5'd7);
    pulse_evt(0, 0, 1, 5'd9);
    check_all();
    pulse_evt(1, 0, 0, 5'd0);
    status_rd(1);
    check_all();

    // Busy overrun and out-of-range register index
    data_wr(8'h77);
    data_wr(8'h88);
    check_all();
    serve(3, 8'h00);
    ctrl_wr(8'h66); ctrl_wr(8'h9F);
    check_all();

    // Upper address bits from the high register and wrap at the top
    ctrl_wr(8'h05); ctrl_wr(8'h8E);
    ctrl_wr(8'h00); ctrl_wr(8'h40);
    data_wr(8'h21); serve(0, 8'h00);
    ctrl_wr(8'h07); ctrl_wr(8'h8E);
    ctrl_wr(8'hFF); ctrl_wr(8'h7F);
    data_wr(8'h31); serve(0, 8'h00);
    data_wr(8'h32); serve(0, 8'h00);
    check_all();

    for (int it = 0; it < 300; it++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: ctrl_wr($urandom_range(0, 1) ? 8'($urandom) : {2'b10, 6'($urandom_range(0, 17))});
        1: data_wr(8'($urandom));
        2: data_rd();
        3: status_rd(1'($urandom_range(0, 1)));
        4: pulse_evt(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
        default: ctrl_wr({2'b00, 6'($urandom)});
      endcase
      if (m_pend) begin
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) != 0) data_wr(8'($urandom));
          else data_rd();
        end
        serve($urandom_range(0, 2), 8'($urandom));
      end
      check_all();
    end

    // Reset in the middle of an access
    data_rd();
    reset = 1;
    @(negedge clk);
    chk("reset_mid_req", 128'(vram_req), 128'(0));
    do_reset();
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
